// File: rtl/router_pkt_src.sv
// Router input-port packet source: buffers a whole payload from the host, then streams
// header, payload and parity to the router while honouring its busy signal.
module router_pkt_src #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       req_bad_parity,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       req_err,
    output logic [7:0] tx_parity
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t        r_state, w_stateNext;
    logic [5:0]    r_count, w_countNext;
    logic [GW-1:0] r_gapCnt, w_gapNext;
    logic [1:0]    r_addr, w_addrNext;
    logic [5:0]    r_len, w_lenNext;
    logic          r_bad, w_badNext;
    logic [7:0]    r_parity, w_parityNext;
    logic          r_pktValid, w_pktValidNext;
    logic [7:0]    r_dataOut, w_dataNext;
    logic          r_txDone, w_txDoneNext;
    logic          r_reqErr, w_reqErrNext;
    logic [7:0]    r_txParity, w_txParityNext;
    logic          w_bufWe;
    logic [7:0]    w_header;

    logic [7:0]    r_buf [0:MAX_LEN-1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_gapCnt   <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_bad      <= 1'b0;
            r_parity   <= '0;
            r_pktValid <= 1'b0;
            r_dataOut  <= '0;
            r_txDone   <= 1'b0;
            r_reqErr   <= 1'b0;
            r_txParity <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_count    <= w_countNext;
            r_gapCnt   <= w_gapNext;
            r_addr     <= w_addrNext;
            r_len      <= w_lenNext;
            r_bad      <= w_badNext;
            r_parity   <= w_parityNext;
            r_pktValid <= w_pktValidNext;
            r_dataOut  <= w_dataNext;
            r_txDone   <= w_txDoneNext;
            r_reqErr   <= w_reqErrNext;
            r_txParity <= w_txParityNext;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_bufWe) begin
            r_buf[r_count] <= wr_data;
        end
    end

    assign w_header = {r_len, r_addr};

    always_comb begin
        w_stateNext    = r_state;
        w_countNext    = r_count;
        w_gapNext      = r_gapCnt;
        w_addrNext     = r_addr;
        w_lenNext      = r_len;
        w_badNext      = r_bad;
        w_parityNext   = r_parity;
        w_pktValidNext = r_pktValid;
        w_dataNext     = r_dataOut;
        w_txDoneNext   = 1'b0;
        w_reqErrNext   = 1'b0;
        w_txParityNext = r_txParity;
        w_bufWe        = 1'b0;

        case (r_state)
            IDLE: begin
                w_pktValidNext = 1'b0;
                w_dataNext     = '0;
                if (req_valid) begin
                    if (req_addr == 2'd3 || req_len == 6'd0) begin
                        w_reqErrNext = 1'b1;
                    end else begin
                        w_addrNext   = req_addr;
                        w_lenNext    = req_len;
                        w_badNext    = req_bad_parity;
                        w_parityNext = {req_len, req_addr};
                        w_countNext  = '0;
                        w_stateNext  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    w_bufWe      = 1'b1;
                    w_parityNext = r_parity ^ wr_data;
                    if (r_count == r_len - 6'd1) begin
                        w_countNext    = '0;
                        w_dataNext     = w_header;
                        w_pktValidNext = 1'b1;
                        w_stateNext    = HEADER;
                    end else begin
                        w_countNext = r_count + 6'd1;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    w_dataNext  = r_buf[0];
                    w_stateNext = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Parity goes out with pkt_valid low, which is what ends the packet at the router.
                if (!busy) begin
                    if (r_count == r_len - 6'd1) begin
                        w_dataNext     = r_parity ^ (r_bad ? 8'hFF : 8'h00);
                        w_pktValidNext = 1'b0;
                        w_stateNext    = PARITY;
                    end else begin
                        w_countNext = r_count + 6'd1;
                        w_dataNext  = r_buf[r_count + 6'd1];
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    w_txDoneNext   = 1'b1;
                    w_txParityNext = r_dataOut;
                    w_dataNext     = '0;
                    w_gapNext      = '0;
                    w_stateNext    = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gapCnt == GW'(GAP_CYCLES - 1)) begin
                    w_gapNext   = '0;
                    w_stateNext = IDLE;
                end else begin
                    w_gapNext = r_gapCnt + GW'(1);
                end
            end
            default: begin
                w_stateNext    = IDLE;
                w_pktValidNext = 1'b0;
                w_dataNext     = '0;
            end
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign wr_ready  = (r_state == LOAD);
    assign pkt_valid = r_pktValid;
    assign data_out  = r_dataOut;
    assign tx_done   = r_txDone;
    assign req_err   = r_reqErr;
    assign tx_parity = r_txParity;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: basic, busy stall, bad parity, rejects,
// max length with load gaps, and reset in the middle of a payload.
module tb_router_pkt_src;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_bad_parity;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       req_err;
    logic [7:0] tx_parity;

    int total = 0;
    int bad   = 0;
    logic [7:0] payload [0:62];

    router_pkt_src #(.MAX_LEN(63), .GAP_CYCLES(1)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_bad_parity(req_bad_parity),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .busy          (busy),
        .pkt_valid     (pkt_valid),
        .data_out      (data_out),
        .tx_done       (tx_done),
        .req_err       (req_err),
        .tx_parity     (tx_parity)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [5:0] len,
                                 input logic badPar, input bit withGaps);
        int lenI;
        lenI = int'(len);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid      = 1'b1;
        req_addr       = addr;
        req_len        = len;
        req_bad_parity = badPar;
        tick;
        req_valid = 1'b0;
        checkOutput("wr_ready_load", 32'(wr_ready), 32'd1);
        for (int i = 0; i < lenI; i++) begin
            if (withGaps && (i % 5 == 2)) begin
                wr_valid = 1'b0;
                wr_data  = 8'hEE;
                tick;
            end
            wr_valid = 1'b1;
            wr_data  = payload[i];
            tick;
        end
        wr_valid = 1'b0;
        checkOutput("wr_ready_after_load", 32'(wr_ready), 32'd0);
    endtask

    task automatic transmitPacket(input logic [5:0] len, input logic [7:0] header,
                                  input logic [7:0] expParity, input int stallIdx,
                                  input int stallCycles);
        int   idx;
        int   cycles;
        int   stallLeft;
        int   pvCount;
        int   lenI;
        bit   done;
        logic obsPv;
        logic [7:0] expData;
        logic expPv;
        idx       = 0;
        cycles    = 0;
        stallLeft = stallCycles;
        pvCount   = 0;
        lenI      = int'(len);
        done      = 1'b0;
        while (!done && cycles < 1000) begin
            if (idx == 0) begin
                expData = header;
                expPv   = 1'b1;
            end else if (idx <= lenI) begin
                expData = payload[idx-1];
                expPv   = 1'b1;
            end else begin
                expData = expParity;
                expPv   = 1'b0;
            end
            checkOutput($sformatf("data_out[%0d]", idx), 32'(data_out), 32'(expData));
            checkOutput($sformatf("pkt_valid[%0d]", idx), 32'(pkt_valid), 32'(expPv));
            checkOutput("tx_done_quiet", 32'(tx_done), 32'd0);
            obsPv = pkt_valid;
            if (idx == stallIdx && stallLeft > 0) begin
                busy = 1'b1;
                stallLeft--;
            end else begin
                busy = 1'b0;
            end
            tick;
            cycles++;
            if (!busy) begin
                if (obsPv === 1'b1) pvCount++;
                if (idx == lenI + 1) done = 1'b1;
                idx++;
            end
        end
        busy = 1'b0;
        checkOutput("tx_timeout", 32'(done), 32'd1);
        checkOutput("pkt_valid_transfers", 32'(pvCount), 32'(lenI + 1));
        checkOutput("tx_done_pulse", 32'(tx_done), 32'd1);
        checkOutput("tx_parity", 32'(tx_parity), 32'(expParity));
        checkOutput("pkt_valid_gap", 32'(pkt_valid), 32'd0);
        checkOutput("data_out_gap", 32'(data_out), 32'd0);
        checkOutput("req_ready_gap", 32'(req_ready), 32'd0);
        tick;
        checkOutput("tx_done_off", 32'(tx_done), 32'd0);
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic setBasicPayload;
        payload[0] = 8'hA5;
        payload[1] = 8'h3C;
        payload[2] = 8'h0F;
    endtask

    initial begin
        resetn         = 1'b0;
        req_valid      = 1'b0;
        req_addr       = '0;
        req_len        = '0;
        req_bad_parity = 1'b0;
        wr_valid       = 1'b0;
        wr_data        = '0;
        busy           = 1'b0;
        tick;
        tick;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
        checkOutput("rst_req_err", 32'(req_err), 32'd0);
        checkOutput("rst_tx_parity", 32'(tx_parity), 32'd0);
        resetn = 1'b1;
        tick;

        $display("[TB] basic packet");
        setBasicPayload();
        applyStimulus(2'd1, 6'd3, 1'b0, 1'b0);
        transmitPacket(6'd3, 8'h0D, 8'h9B, -1, 0);

        $display("[TB] busy stall on 3C");
        applyStimulus(2'd1, 6'd3, 1'b0, 1'b0);
        transmitPacket(6'd3, 8'h0D, 8'h9B, 2, 3);

        $display("[TB] parity corruption");
        applyStimulus(2'd1, 6'd3, 1'b1, 1'b0);
        transmitPacket(6'd3, 8'h0D, 8'h64, -1, 0);

        $display("[TB] rejected requests");
        req_valid = 1'b1;
        req_addr  = 2'd3;
        req_len   = 6'd5;
        tick;
        req_valid = 1'b0;
        checkOutput("rej_addr_err", 32'(req_err), 32'd1);
        checkOutput("rej_addr_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("rej_addr_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("rej_addr_req_ready", 32'(req_ready), 32'd1);
        tick;
        checkOutput("rej_addr_err_off", 32'(req_err), 32'd0);
        req_valid = 1'b1;
        req_addr  = 2'd0;
        req_len   = 6'd0;
        tick;
        req_valid = 1'b0;
        checkOutput("rej_len_err", 32'(req_err), 32'd1);
        checkOutput("rej_len_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("rej_len_pkt_valid", 32'(pkt_valid), 32'd0);
        tick;
        checkOutput("rej_len_err_off", 32'(req_err), 32'd0);
        checkOutput("rej_len_pkt_valid_after", 32'(pkt_valid), 32'd0);

        $display("[TB] max length packet");
        for (int i = 0; i < 63; i++) payload[i] = 8'(i);
        applyStimulus(2'd2, 6'd63, 1'b0, 1'b1);
        transmitPacket(6'd63, 8'hFE, 8'hC1, -1, 0);

        $display("[TB] reset mid payload");
        setBasicPayload();
        applyStimulus(2'd1, 6'd3, 1'b0, 1'b0);
        busy = 1'b0;
        tick;
        tick;
        tick;
        checkOutput("mid_before_reset", 32'(data_out), 32'h0F);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("mid_rst_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("mid_rst_data_out", 32'(data_out), 32'd0);
        checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd1);
        tick;
        checkOutput("mid_rst_tx_done", 32'(tx_done), 32'd0);
        tick;
        resetn = 1'b1;
        tick;
        checkOutput("mid_after_tx_done", 32'(tx_done), 32'd0);
        checkOutput("mid_after_req_ready", 32'(req_ready), 32'd1);
        checkOutput("mid_after_tx_parity", 32'(tx_parity), 32'd0);
        applyStimulus(2'd1, 6'd3, 1'b0, 1'b0);
        transmitPacket(6'd3, 8'h0D, 8'h9B, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
